// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: op codes, FSM states
// and the iteration count used by the multi-cycle operations.
package calc_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MULT = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int iter_count(input int w);
        return w;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// W-bit restoring divider: loads on start, then one quotient bit per cycle.
// quotient/remainder are the final-step values, valid while done is high.
module seq_divider #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    import calc_pkg::*;

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [W:0]    shifted, trial;
    logic          fits;
    logic [W-1:0]  rem_step, quo_step;

    assign shifted  = {rem_q, quo_q[W-1]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign fits     = ~trial[W];
    assign rem_step = fits ? trial[W-1:0] : shifted[W-1:0];
    assign quo_step = {quo_q[W-2:0], fits};

    assign done      = (cnt_q == CW'(1));
    assign quotient  = quo_step;
    assign remainder = rem_step;

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        if (start) begin
            cnt_d = CW'(iter_count(W));
            rem_d = '0;
            quo_d = a;
            dsr_d = b;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            rem_d = rem_step;
            quo_d = quo_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
        end
    end

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle W-bit calculator with valid/ready handshakes on both sides.
// Define CALC_DIV_EN to build the iterative divider; otherwise every DIV reports err.
module seq_calculator #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           err
);
    import calc_pkg::*;

    localparam int CW = $clog2(W + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic [2*W-1:0] result_q, result_d, prod_q, prod_d, mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic           err_q, err_d;

    logic           accept, go_busy, busy_last, quick_err;
    logic [2*W-1:0] prod_step, quick_res, busy_res;
    logic [W:0]     sum;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef CALC_DIV_EN
    logic         div_start, div_done;
    logic [W-1:0] div_quo, div_rem;

    assign div_start = accept && (op == OP_DIV) && (b != '0);
    assign go_busy   = (op == OP_MULT) || div_start;
    assign busy_last = (op_q == OP_DIV) ? div_done : (cnt_q == CW'(1));
    assign busy_res  = (op_q == OP_DIV) ? {div_rem, div_quo} : prod_step;

    seq_divider #(.W(W)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .a         (a),
        .b         (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign go_busy   = (op == OP_MULT);
    assign busy_last = (cnt_q == CW'(1)) && (op_q == OP_MULT);
    assign busy_res  = prod_step;
`endif

    // Single-cycle results; DIV only lands here for b==0 or without a divider.
    always_comb begin
        quick_res = '0;
        quick_err = 1'b0;
        case (op)
            OP_AND:  quick_res = {{W{1'b0}}, a & b};
            OP_OR:   quick_res = {{W{1'b0}}, a | b};
            OP_NOT:  quick_res = {{W{1'b1}}, ~a};
            OP_XOR:  quick_res = {{W{1'b0}}, a ^ b};
            OP_ADD:  quick_res = {{(W-1){1'b0}}, sum};
            OP_SUB:  quick_res = {{W{a < b}}, a - b};
            OP_DIV: begin
                quick_res = '1;
                quick_err = 1'b1;
            end
            default: quick_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = op;
                    if (go_busy) begin
                        state_d  = BUSY;
                        cnt_d    = CW'(iter_count(W));
                        prod_d   = '0;
                        mcand_d  = {{W{1'b0}}, a};
                        mplier_d = b;
                    end else begin
                        state_d  = DONE;
                        result_d = quick_res;
                        err_d    = quick_err;
                    end
                end
            end
            BUSY: begin
                cnt_d    = cnt_q - CW'(1);
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (busy_last) begin
                    state_d  = DONE;
                    result_d = busy_res;
                    err_d    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
            err_q    <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator at W=4 and W=8, with and without CALC_DIV_EN.
module tb_seq_calculator;
    import calc_pkg::*;

    typedef struct {
        bit          wide;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        int          lat;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       v4 = 1'b0, ordy4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] op4 = '0;
    logic       r4, ov4, e4;
    logic [7:0] res4;

    logic       v8 = 1'b0, ordy8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [2:0] op8 = '0;
    logic       r8, ov8, e8;
    logic [15:0] res8;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_calculator #(.W(4)) u_calc4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .out_ready(ordy4), .result(res4), .err(e4)
    );

    seq_calculator #(.W(8)) u_calc8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(ordy8), .result(res8), .err(e8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        lat = 0;
        while (!(v.wide ? r8 : r4) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({v.name, " ready"}, 32'(v.wide ? r8 : r4), 32'd1);
        if (v.wide) begin
            op8 = v.op; a8 = v.a; b8 = v.b; v8 = 1'b1;
        end else begin
            op4 = v.op; a4 = v.a[3:0]; b4 = v.b[3:0]; v4 = 1'b1;
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        v8 = 1'b0;
        checkOutput({v.name, " ready drop"}, 32'(v.wide ? r8 : r4), 32'd0);
        lat = 1;
        while (!(v.wide ? ov8 : ov4) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({v.name, " latency"}, 32'(lat), 32'(v.lat));
        checkOutput({v.name, " result"}, v.wide ? 32'(res8) : 32'(res4), 32'(v.res));
        checkOutput({v.name, " err"}, 32'(v.wide ? e8 : e4), 32'(v.err));
        ordy4 = 1'b1;
        ordy8 = 1'b1;
        @(posedge clk); #1;
        ordy4 = 1'b0;
        ordy8 = 1'b0;
        checkOutput({v.name, " valid drop"}, 32'(v.wide ? ov8 : ov4), 32'd0);
        checkOutput({v.name, " ready back"}, 32'(v.wide ? r8 : r4), 32'd1);
    endtask

    function automatic vec_t mk(input bit wide, input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [15:0] res, input logic err,
                                input int lat, input string name);
        vec_t v;
        v.wide = wide; v.op = op; v.a = a; v.b = b;
        v.res = res; v.err = err; v.lat = lat; v.name = name;
        return v;
    endfunction

    initial begin
        int seen;

        vecs.push_back(mk(0, OP_ADD,  8'd9,  8'd8,  16'h0011, 0, 1, "add 9+8"));
        vecs.push_back(mk(0, OP_SUB,  8'd3,  8'd5,  16'h00FE, 0, 1, "sub 3-5"));
        vecs.push_back(mk(0, OP_NOT,  8'h5,  8'h0,  16'h00FA, 0, 1, "not 5"));
        vecs.push_back(mk(0, OP_AND,  8'hC,  8'hA,  16'h0008, 0, 1, "and C,A"));
        vecs.push_back(mk(0, OP_OR,   8'hC,  8'hA,  16'h000E, 0, 1, "or C,A"));
        vecs.push_back(mk(0, OP_XOR,  8'hC,  8'hA,  16'h0006, 0, 1, "xor C,A"));
        vecs.push_back(mk(0, OP_ADD,  8'hF,  8'hF,  16'h001E, 0, 1, "add F+F"));
        vecs.push_back(mk(0, OP_SUB,  8'd5,  8'd3,  16'h0002, 0, 1, "sub 5-3"));
        vecs.push_back(mk(0, OP_MULT, 8'hF,  8'hF,  16'h00E1, 0, 5, "mult F*F"));
        vecs.push_back(mk(0, OP_MULT, 8'd0,  8'd7,  16'h0000, 0, 5, "mult 0*7"));
        vecs.push_back(mk(0, OP_MULT, 8'd6,  8'd5,  16'h001E, 0, 5, "mult 6*5"));
        vecs.push_back(mk(0, OP_DIV,  8'd7,  8'd0,  16'h00FF, 1, 1, "div 7/0"));
        vecs.push_back(mk(1, OP_MULT, 8'd255, 8'd255, 16'hFE01, 0, 9, "w8 mult 255*255"));
        vecs.push_back(mk(1, OP_ADD,  8'd200, 8'd100, 16'h012C, 0, 1, "w8 add 200+100"));
        vecs.push_back(mk(1, OP_SUB,  8'd10,  8'd20,  16'hFFF6, 0, 1, "w8 sub 10-20"));
`ifdef CALC_DIV_EN
        vecs.push_back(mk(0, OP_DIV,  8'd13, 8'd4,  16'h0013, 0, 5, "div 13/4"));
        vecs.push_back(mk(0, OP_DIV,  8'd15, 8'd1,  16'h000F, 0, 5, "div 15/1"));
        vecs.push_back(mk(0, OP_DIV,  8'd2,  8'd9,  16'h0020, 0, 5, "div 2/9"));
        vecs.push_back(mk(1, OP_DIV,  8'd200, 8'd7, 16'h041C, 0, 9, "w8 div 200/7"));
`else
        vecs.push_back(mk(0, OP_DIV,  8'd13, 8'd4,  16'h00FF, 1, 1, "div 13/4 nodiv"));
        vecs.push_back(mk(1, OP_DIV,  8'd200, 8'd7, 16'hFFFF, 1, 1, "w8 div 200/7 nodiv"));
`endif

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(ov4), 32'd0);
        checkOutput("reset in_ready", 32'(r4), 32'd0);
        checkOutput("reset result", 32'(res4), 32'd0);
        checkOutput("reset err", 32'(e4), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after release", 32'(r4), 32'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Backpressure: result must hold while out_ready stays low.
        op4 = OP_ADD; a4 = 4'd9; b4 = 4'd8; v4 = 1'b1;
        @(posedge clk); #1;
        op4 = OP_AND; a4 = 4'd0; b4 = 4'd0;
        checkOutput("bp out_valid", 32'(ov4), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp result stable", 32'(res4), 32'h11);
            checkOutput("bp in_ready low", 32'(r4), 32'd0);
            checkOutput("bp out_valid held", 32'(ov4), 32'd1);
            v4 = ~v4;
            @(posedge clk); #1;
        end
        checkOutput("bp result after toggles", 32'(res4), 32'h11);
        v4 = 1'b0;
        ordy4 = 1'b1;
        @(posedge clk); #1;
        ordy4 = 1'b0;
        checkOutput("bp release valid", 32'(ov4), 32'd0);
        checkOutput("bp release ready", 32'(r4), 32'd1);
        applyStimulus(mk(0, OP_OR, 8'h3, 8'h4, 16'h0007, 0, 1, "or after bp"));

        // Reset in the middle of a multiply aborts it.
        op4 = OP_MULT; a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort out_valid", 32'(ov4), 32'd0);
        checkOutput("abort in_ready", 32'(r4), 32'd0);
        checkOutput("abort result", 32'(res4), 32'd0);
        checkOutput("abort err", 32'(e4), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov4) seen++;
            @(posedge clk); #1;
        end
        checkOutput("abort no out_valid", 32'(seen), 32'd0);
        applyStimulus(mk(0, OP_AND, 8'hC, 8'hA, 16'h0008, 0, 1, "and after abort"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
